slave_fifo: RTL

- Per-channel input buffer of the MCDT, one instance per slave port. Three instances feed the round-robin arbiter.
- Accepts words from a channel master with a valid/ready handshake and stores them in a synchronous FIFO.
- Raises a request to the arbiter while data is held. Presents one word per granted cycle on the slave data/valid lines.

---
 rtl/slave_fifo.sv | 83 ++++++++
 1 files changed

// File: rtl/slave_fifo.sv
// MCDT per-channel slave FIFO: valid/ready write side, req/ack read side.
// Optional sticky overflow flag built when SLV_FIFO_OVF_CHK_EN is defined.
module slave_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] chnl_data_i,
  input  logic          chnl_valid_i,
  output logic          chnl_ready_o,
  input  logic          slv_en_i,
  output logic [DW-1:0] slv_data_o,
  output logic          slv_req_o,
  output logic          slv_val_o,
  input  logic          a2s_ack_i,
  output logic [AW:0]   slv_margin_o,
  output logic          slv_ovf_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [AW:0]   count;
  logic          en;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // Gating with rstn_i keeps the handshake outputs low while in reset.
  assign en    = slv_en_i & rstn_i;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                 (wptr[AW] != rptr[AW]);
  assign count = wptr - rptr;

  assign chnl_ready_o = en & ~full;
  assign push         = chnl_valid_i & chnl_ready_o;
  assign slv_req_o    = en & ~empty;
  assign slv_val_o    = a2s_ack_i & slv_req_o;
  assign pop          = slv_val_o;

  assign slv_data_o   = slv_val_o ? mem[rptr[AW-1:0]] : '0;
  assign slv_margin_o = (AW+1)'(DEPTH) - count;

  // Storage array; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= chnl_data_i;
    end
  end

  // Wrap-bit pointers advance on push and pop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

`ifdef SLV_FIFO_OVF_CHK_EN
  logic ovf_q;

  // Sticky flag for a write attempted into a full FIFO.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf_q <= 1'b0;
    end else if (chnl_valid_i & full & en) begin
      ovf_q <= 1'b1;
    end
  end

  assign slv_ovf_o = ovf_q;
`else
  assign slv_ovf_o = 1'b0;
`endif

endmodule
